byass_expand: RTL and testbench

Receive-side counterpart of the 20-to-8-bit window selector. It accepts a framed byte stream made of a sync byte, a shift code, a sample count and N 8-bit windowed samples. It rebuilds each sample as a 20-bit value aligned at the transmitted shift position, and flags malformed or stalled frames. It sits after the byte link, ahead of the 20-bit TDC/histogram consumers.

---
 rtl/byass_expand_if.sv | 22 ++
 rtl/byass_expand.sv | 116 +++++++++++
 tb/tb_byass_expand.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/byass_expand_if.sv
// Byte-link receive bus for byass_expand: framed byte input, 20-bit sample output.
// The master side drives bytes in; the slave side (the decoder) drives results out.
interface byass_expand_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_valid;
    logic [19:0] out_data;
    logic [3:0]  out_shift;
    logic        frame_start;
    logic        frame_end;
    logic        err;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_data, out_shift, frame_start, frame_end, err
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_data, out_shift, frame_start, frame_end, err
    );
endinterface

// File: rtl/byass_expand.sv
// Frame decoder that rebuilds 20-bit samples from 8-bit windowed bytes
// (sync, shift code, count, N samples) and flags malformed or stalled frames.
module byass_expand #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_SHIFT = 12,
    parameter bit         ROUND     = 1'b0,
    parameter int         TIMEOUT   = 1024
) (
    input logic          clk,
    input logic          rst,
    byass_expand_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] COUNT = 2'd2;
    localparam logic [1:0] DATA  = 2'd3;

    logic [1:0]       state;
    logic [7:0]       remain;
    logic [CNT_W-1:0] idle_cnt;

    logic             vld_p1;
    logic [19:0]      data_p1;
    logic [3:0]       shift_p1;
    logic             start_p1;
    logic             end_p1;
    logic             err_p1;

    // Place the window back at its transmitted position; optional half-LSB fill below it.
    function automatic logic [19:0] expand(input logic [7:0] d, input logic [3:0] sh);
        logic [19:0] v;
        v = 20'(d) << sh;
        if (ROUND && (sh != 4'd0))
            v = v | (20'd1 << (sh - 4'd1));
        return v;
    endfunction

    // Stage p0 -> p1: decode the accepted byte and register every output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            remain   <= 8'd0;
            idle_cnt <= '0;
            vld_p1   <= 1'b0;
            data_p1  <= 20'd0;
            shift_p1 <= 4'd5;
            start_p1 <= 1'b0;
            end_p1   <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            vld_p1   <= 1'b0;
            start_p1 <= 1'b0;
            end_p1   <= 1'b0;
            err_p1   <= 1'b0;

            if (bus.in_valid) begin
                idle_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (bus.in_data == SYNC_BYTE)
                            state <= SHIFT;
                    end
                    SHIFT: begin
                        if (bus.in_data <= 8'(MAX_SHIFT)) begin
                            shift_p1 <= bus.in_data[3:0];
                            state    <= COUNT;
                        end else begin
                            err_p1 <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    COUNT: begin
                        if (bus.in_data == 8'd0) begin
                            err_p1 <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            remain   <= bus.in_data;
                            start_p1 <= 1'b1;
                            state    <= DATA;
                        end
                    end
                    DATA: begin
                        // A sync-valued byte here is payload, never a resync.
                        data_p1 <= expand(bus.in_data, shift_p1);
                        vld_p1  <= 1'b1;
                        remain  <= remain - 8'd1;
                        if (remain == 8'd1) begin
                            end_p1 <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                // A stalled frame is dropped; samples already emitted stand.
                if (idle_cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_p1   <= 1'b1;
                    state    <= IDLE;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.out_valid   = vld_p1;
    assign bus.out_data    = data_p1;
    assign bus.out_shift   = shift_p1;
    assign bus.frame_start = start_p1;
    assign bus.frame_end   = end_p1;
    assign bus.err         = err_p1;

endmodule

// File: tb/tb_byass_expand.sv
// Bench for byass_expand: directed frames from the test plan plus random frames,
// checked against a frame-level model on a ROUND=0 and a ROUND=1 instance.
module tb_byass_expand;
    localparam int         TO   = 1024;
    localparam logic [7:0] SYNC = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    byass_expand_if bus0 ();
    byass_expand_if bus1 ();

    byass_expand #(.SYNC_BYTE(SYNC), .MAX_SHIFT(12), .ROUND(1'b0), .TIMEOUT(TO)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    byass_expand #(.SYNC_BYTE(SYNC), .MAX_SHIFT(12), .ROUND(1'b1), .TIMEOUT(TO)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int          checks = 0;
    int          errors = 0;
    logic [19:0] exp_d0 = 20'd0;
    logic [19:0] exp_d1 = 20'd0;
    logic [3:0]  exp_sh = 4'd5;
    logic [7:0]  payload[$];

    // Sample value times 2^shift, plus half an LSB when rounding is requested.
    function automatic logic [19:0] ref_expand(input int d, input int sh, input bit rnd);
        int r;
        r = d * (1 << sh);
        if (rnd && sh > 0) r = r + (1 << (sh - 1));
        return 20'(r);
    endfunction

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input bit e_vld, input bit e_start, input bit e_end, input bit e_err);
        chk("vld0",   20'(bus0.out_valid),   20'(e_vld));
        chk("start0", 20'(bus0.frame_start), 20'(e_start));
        chk("end0",   20'(bus0.frame_end),   20'(e_end));
        chk("err0",   20'(bus0.err),         20'(e_err));
        chk("data0",  bus0.out_data,         exp_d0);
        chk("shift0", 20'(bus0.out_shift),   20'(exp_sh));
        chk("vld1",   20'(bus1.out_valid),   20'(e_vld));
        chk("start1", 20'(bus1.frame_start), 20'(e_start));
        chk("end1",   20'(bus1.frame_end),   20'(e_end));
        chk("err1",   20'(bus1.err),         20'(e_err));
        chk("data1",  bus1.out_data,         exp_d1);
        chk("shift1", 20'(bus1.out_shift),   20'(exp_sh));
    endtask

    task automatic step(input bit v, input logic [7:0] b,
                        input bit e_vld, input bit e_start, input bit e_end, input bit e_err);
        @(negedge clk);
        bus0.in_valid = v; bus0.in_data = b;
        bus1.in_valid = v; bus1.in_data = b;
        @(posedge clk);
        #1;
        if (e_vld) begin
            exp_d0 = ref_expand(int'(b), int'(exp_sh), 1'b0);
            exp_d1 = ref_expand(int'(b), int'(exp_sh), 1'b1);
        end
        expect_out(e_vld, e_start, e_end, e_err);
    endtask

    task automatic gap(input int gapmax);
        int n;
        n = int'($urandom_range(0, gapmax));
        repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame(input int sh, input int gapmax);
        step(1'b1, SYNC, 1'b0, 1'b0, 1'b0, 1'b0);
        gap(gapmax);
        exp_sh = 4'(sh);
        step(1'b1, 8'(sh), 1'b0, 1'b0, 1'b0, 1'b0);
        gap(gapmax);
        step(1'b1, 8'(payload.size()), 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < payload.size(); i++) begin
            gap(gapmax);
            step(1'b1, payload[i], 1'b1, 1'b0, (i == payload.size() - 1), 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_data = 8'h00;
        bus1.in_valid = 1'b0; bus1.in_data = 8'h00;
        @(posedge clk);
        #1;
        exp_d0 = 20'd0;
        exp_d1 = 20'd0;
        exp_sh = 4'd5;
        expect_out(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        bus0.in_valid = 1'b0; bus0.in_data = 8'h00;
        bus1.in_valid = 1'b0; bus1.in_data = 8'h00;
        repeat (2) @(posedge clk);
        do_reset();

        // Basic frame
        payload = '{8'h12, 8'hFF, 8'h80};
        frame(5, 0);
        chk("basic_last", bus0.out_data, 20'h01000);

        // Shift extremes and rounding
        payload = '{8'hFF};
        frame(0, 0);
        chk("shift0_ff", bus0.out_data, 20'h000FF);
        frame(12, 0);
        chk("shift12_ff", bus0.out_data, 20'hFF000);
        payload = '{8'h01};
        frame(4, 0);
        chk("round_s4", bus1.out_data, 20'h00018);

        // Illegal shift, then zero count, then a clean frame
        step(1'b1, SYNC, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, SYNC, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_sh = 4'd3;
        step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        payload = '{8'h3C, 8'h81};
        frame(7, 1);

        // Garbage before sync, then sync-valued payload
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        payload = '{8'hA5, 8'h01};
        frame(2, 0);
        chk("insync_last", bus0.out_data, 20'h00004);

        // Timeout after one of four samples
        step(1'b1, SYNC, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_sh = 4'd3;
        step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= TO; j++)
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, (j == TO));
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        payload = '{8'h11, 8'h22};
        frame(1, 0);

        // Reset with five samples still outstanding
        step(1'b1, SYNC, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_sh = 4'd6;
        step(1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        payload = '{8'hC3, 8'h0F, 8'hF0};
        frame(9, 0);

        // Random frames with idle gaps and inter-frame garbage
        for (int f = 0; f < 30; f++) begin
            int ng;
            int n;
            ng = int'($urandom_range(0, 2));
            for (int g = 0; g < ng; g++) begin
                logic [7:0] gb;
                gb = 8'($urandom);
                if (gb == SYNC) gb = 8'h00;
                step(1'b1, gb, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            n = int'($urandom_range(1, 8));
            payload.delete();
            repeat (n) payload.push_back(8'($urandom));
            frame(int'($urandom_range(0, 12)), 3);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
